// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler and counter, per-channel
// double-buffered duty, edge- or centre-aligned counting, per-channel polarity.
module pwm_multi #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned RES        = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    mode,
  input  logic [PRESCALE_W-1:0]   prescale,
  input  logic [CHANNELS*RES-1:0] duty,
  input  logic [CHANNELS-1:0]     duty_we,
  input  logic [CHANNELS-1:0]     polarity,
  output logic [CHANNELS-1:0]     pwm_out,
  output logic                    period_start
);

  // Highest counter value; full scale duty M = 2^RES-1 is never reached by cnt.
  localparam logic [RES-1:0] CNT_TOP = {{(RES-1){1'b1}}, 1'b0};
  localparam logic           MODE_EDGE = 1'b0;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PRESCALE_W-1:0] pcnt;
  logic [PRESCALE_W-1:0] pcnt_nxt;
  logic [RES-1:0]        cnt;
  logic [RES-1:0]        cnt_nxt;
  dir_t                  dir;
  dir_t                  dir_nxt;
  logic                  mode_act;
  logic [RES-1:0]        shadow [CHANNELS];
  logic [RES-1:0]        active [CHANNELS];
  logic                  tick;
  logic                  boundary;
  logic [CHANNELS-1:0]   cmp;

  // Prescaler: >= compare so a shrinking prescale ticks at once instead of running away.
  always_comb begin
    tick     = 1'b0;
    pcnt_nxt = pcnt;
    if (!en) begin
      pcnt_nxt = '0;
    end else if (pcnt >= prescale) begin
      tick     = 1'b1;
      pcnt_nxt = '0;
    end else begin
      pcnt_nxt = PRESCALE_W'(pcnt + 1'b1);
    end
  end

  // Period counter; centre mode holds each endpoint for two ticks.
  always_comb begin
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (!en) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (tick) begin
      if (mode_act == MODE_EDGE) begin
        dir_nxt = DIR_UP;
        if (cnt == CNT_TOP) begin
          cnt_nxt  = '0;
          boundary = 1'b1;
        end else begin
          cnt_nxt = RES'(cnt + 1'b1);
        end
      end else if (dir == DIR_UP) begin
        if (cnt == CNT_TOP) begin
          dir_nxt = DIR_DOWN;
        end else begin
          cnt_nxt = RES'(cnt + 1'b1);
        end
      end else begin
        if (cnt == '0) begin
          dir_nxt  = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_nxt = RES'(cnt - 1'b1);
        end
      end
    end
  end

  always_comb begin
    cmp = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cmp[i] = (cnt < active[i]) ^ polarity[i];
    end
  end

  // Shadow writes land after the boundary copy, so a same-clock write waits a period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt         <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      mode_act     <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      pcnt <= pcnt_nxt;
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
      if (!en || boundary) begin
        mode_act <= mode;
        for (int i = 0; i < int'(CHANNELS); i++) begin
          active[i] <= shadow[i];
        end
      end
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (duty_we[i]) begin
          shadow[i] <= duty[i*RES +: RES];
        end
      end
      pwm_out      <= en ? cmp : polarity;
      period_start <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi (RES=4): period-position model checked every cycle,
// plus directed windows with hand-computed high-time and strobe counts.
module tb_pwm_multi;

  localparam int unsigned CH  = 4;
  localparam int unsigned RES = 4;
  localparam int unsigned PW  = 16;
  localparam int          M   = (1 << RES) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              mode;
  logic [PW-1:0]     prescale;
  logic [CH*RES-1:0] duty;
  logic [CH-1:0]     duty_we;
  logic [CH-1:0]     polarity;
  logic [CH-1:0]     pwm_out;
  logic              period_start;

  pwm_multi #(.CHANNELS(CH), .RES(RES), .PRESCALE_W(PW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .prescale(prescale),
    .duty(duty), .duty_we(duty_we), .polarity(polarity),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  function automatic void chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Model: position within the period; centre mode folds it into an up/down count.
  int              mp = 0;
  int              phase = 0;
  logic            mmode = 1'b0;
  logic [RES-1:0]  msh [CH];
  logic [RES-1:0]  mact [CH];
  logic [CH-1:0]   exp_pwm = '0;
  logic            exp_ps = 1'b0;

  function automatic int fold(int ph, logic md);
    if (!md) return ph;
    return (ph < M) ? ph : 2*M - 1 - ph;
  endfunction

  initial forever begin : model
    logic [CH-1:0] nxt;
    logic          bnd;
    int            c;
    @(posedge clk);
    if (!reset) begin
      mp = 0; phase = 0; mmode = 1'b0;
      for (int i = 0; i < int'(CH); i++) begin msh[i] = '0; mact[i] = '0; end
      exp_pwm = '0; exp_ps = 1'b0;
    end else begin
      c = fold(phase, mmode);
      for (int i = 0; i < int'(CH); i++)
        nxt[i] = en ? ((c < int'(mact[i])) ^ polarity[i]) : polarity[i];
      bnd = 1'b0;
      if (!en) begin
        mp = 0; phase = 0; mmode = mode;
        for (int i = 0; i < int'(CH); i++) mact[i] = msh[i];
      end else begin
        if (mp >= int'(prescale)) begin
          mp = 0;
          phase++;
          if (phase == (mmode ? 2*M : M)) begin
            phase = 0;
            bnd = 1'b1;
          end
        end else begin
          mp++;
        end
        if (bnd) begin
          mmode = mode;
          for (int i = 0; i < int'(CH); i++) mact[i] = msh[i];
        end
      end
      for (int i = 0; i < int'(CH); i++)
        if (duty_we[i]) msh[i] = duty[i*RES +: RES];
      exp_pwm = nxt;
      exp_ps  = bnd;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("pwm_out", int'(pwm_out), int'(exp_pwm));
      chk("period_start", int'(period_start), int'(exp_ps));
    end
  end

  // Sample recorder, indexed from the last period_start seen by wait_ps.
  logic [CH-1:0] samp [0:127];
  logic          psamp [0:127];
  int            kidx = 0;

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (kidx < 127) kidx++;
      samp[kidx]  = pwm_out;
      psamp[kidx] = period_start;
    end
  endtask

  task automatic wait_ps(input int lim);
    bit found = 1'b0;
    for (int n = 0; n < lim && !found; n++) begin
      @(negedge clk);
      if (period_start) found = 1'b1;
    end
    kidx = 0;
    samp[0]  = pwm_out;
    psamp[0] = period_start;
    if (!found) begin
      total++;
      bad++;
      $display("FAIL wait_ps: no period_start within %0d clocks", lim);
    end
  endtask

  task automatic wr(input int ch, input logic [RES-1:0] v);
    duty[ch*RES +: RES] = v;
    duty_we[ch] = 1'b1;
  endtask

  function automatic int hi(int ch, int a, int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(samp[k][ch]);
    return s;
  endfunction

  function automatic int psn(int a, int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(psamp[k]);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; mode = 1'b0; prescale = '0;
    duty = '0; duty_we = '0; polarity = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    reset = 1'b1;

    // Edge mode, duties 5/0/15/8.
    wr(0, 4'd5); wr(1, 4'd0); wr(2, 4'd15); wr(3, 4'd8);
    step(1); duty_we = '0;
    en = 1'b1;
    wait_ps(100);
    step(30);
    chk("edge_ch0", hi(0, 1, 15), 5);
    chk("edge_ch0_p2", hi(0, 16, 30), 5);
    chk("edge_ch1", hi(1, 1, 30), 0);
    chk("edge_ch2", hi(2, 1, 30), 30);
    chk("edge_ch3", hi(3, 1, 15), 8);
    chk("edge_ps_cnt", psn(1, 30), 2);
    chk("edge_ps_at15", int'(psamp[15]), 1);

    // Centre mode takes over at the next boundary.
    mode = 1'b1;
    wait_ps(100);
    step(60);
    chk("ctr_ch0", hi(0, 1, 30), 10);
    chk("ctr_ch0_straddle", hi(0, 26, 35), 10);
    chk("ctr_ch0_mid", hi(0, 36, 55), 0);
    chk("ctr_ch3", hi(3, 1, 30), 16);
    chk("ctr_ps_cnt", psn(1, 60), 2);
    chk("ctr_ps_at30", int'(psamp[30]), 1);

    // Back to edge with duty 10; mid-period write 3, boundary write 7.
    mode = 1'b0;
    wr(0, 4'd10); step(1); duty_we = '0;
    wait_ps(100);
    step(4); wr(0, 4'd3); step(1); duty_we = '0;
    step(24); wr(0, 4'd7); step(1); duty_we = '0;
    step(30);
    chk("shadow_cur", hi(0, 1, 15), 10);
    chk("shadow_next", hi(0, 16, 30), 3);
    chk("shadow_bnd_old", hi(0, 31, 45), 3);
    chk("shadow_bnd_new", hi(0, 46, 60), 7);
    chk("shadow_ps_cnt", psn(1, 60), 4);

    // Prescale 3: each count lasts 4 clocks.
    prescale = 16'd3;
    wr(0, 4'd5); wr(1, 4'd1); step(1); duty_we = '0;
    wait_ps(400);
    step(60);
    chk("pre_ch0", hi(0, 1, 60), 20);
    chk("pre_ch1", hi(1, 1, 60), 4);
    chk("pre_ps_none", psn(1, 59), 0);
    chk("pre_ps_at60", int'(psamp[60]), 1);
    // Shrinking prescale 10 -> 2 with pcnt=7 ticks on the next clock.
    prescale = 16'd10;
    step(7);
    prescale = 16'd2;
    step(2);
    chk("shrink_hold", hi(1, 61, 68), 8);
    chk("shrink_tick", int'(samp[69][1]), 0);
    prescale = '0;

    // Inverted channel 0, then disable at cnt=2 and re-enable.
    polarity = 4'b0001;
    wait_ps(400);
    step(15);
    chk("pol_ch0", hi(0, 1, 15), 10);
    step(2);
    en = 1'b0;
    step(1);
    chk("dis_ch0", int'(samp[18][0]), 1);
    step(5);
    chk("dis_hold", hi(0, 18, 23), 6);
    chk("dis_ps", psn(18, 23), 0);
    en = 1'b1;
    step(15);
    chk("reen_low", hi(0, 24, 28), 0);
    chk("reen_high", hi(0, 29, 38), 10);
    chk("reen_ps_none", psn(24, 37), 0);
    chk("reen_ps_at38", int'(psamp[38]), 1);

    // Mid-period mode switch, then reset at cnt=9.
    polarity = '0;
    wait_ps(100);
    step(5);
    mode = 1'b1;
    step(40);
    chk("sw_edge", hi(0, 1, 15), 5);
    chk("sw_edge_ps", int'(psamp[15]), 1);
    chk("sw_ctr", hi(0, 16, 45), 10);
    chk("sw_ctr_ps_none", psn(16, 44), 0);
    chk("sw_ctr_ps_at45", int'(psamp[45]), 1);
    step(9);
    chk("pre_rst_vec", int'(samp[54]), 4);
    reset = 1'b0;
    step(1);
    chk("rst_mid_pwm", int'(samp[55]), 0);
    chk("rst_mid_ps", int'(psamp[55]), 0);
    reset = 1'b1;
    step(40);
    chk("post_rst_hi", hi(0, 56, 95) + hi(1, 56, 95) + hi(2, 56, 95) + hi(3, 56, 95), 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel, parametrised PWM generator; next generation of the single-duty-input brightness PWM used for the seven-segment display multiplexing.
- Adds per-channel duty with shadow/active double buffering, a shared prescaler, edge- or centre-aligned mode, per-channel output polarity and a period-start strobe.
- Drives LED and segment brightness and any other on-board PWM loads from one shared time base.

Parameters:
- CHANNELS, 4, number of independent PWM outputs.
- RES, 8, duty and counter resolution in bits. Full scale M = 2^RES-1.
- PRESCALE_W, 16, width of the prescale input.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  run enable.
- mode  in  1  0 = edge-aligned, 1 = centre-aligned.
- prescale  in  PRESCALE_W  a counter tick occurs every prescale+1 clocks.
- duty  in  CHANNELS*RES  packed duty values. Channel i uses bits [i*RES +: RES].
- duty_we  in  CHANNELS  per-channel write strobe into the shadow register.
- polarity  in  CHANNELS  1 = invert the output of that channel.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  one-clock pulse at each period boundary.

Behaviour:
- Reset (reset=0 at a clock edge) clears the following to 0: prescaler count, cnt, direction (up), mode_act, all shadow registers, all active registers, pwm_out and period_start.
- Prescaler:
  - pcnt increments every clock while en=1.
  - When pcnt >= prescale, tick=1 and pcnt returns to 0.
  - prescale=0 gives a tick every clock.
  - A change to prescale applies immediately. The >= compare prevents a runaway count when prescale shrinks.
- Edge mode:
  - On each tick, cnt steps 0,1,…,M-1, then wraps to 0.
  - Period = M ticks.
- Centre mode:
  - On each tick, cnt counts up 0…M-1, then down M-1…0. Both endpoints are held for two ticks.
  - Period = 2M ticks.
- Period boundary: the tick that returns cnt to 0 and starts a new period.
  - Edge mode: the wrap from M-1 to 0.
  - Centre mode: the tick after the second 0.
  - At this tick, active[i] <= shadow[i] for all i, mode_act <= mode, and period_start pulses high in the following clock.
- Compare:
  - pwm_out[i] is registered as (cnt < active[i]) XOR polarity[i].
  - Latency is 1 clock from the cnt value to the output.
  - duty=0 gives constant inactive. duty=M gives constant active.
  - High time is duty ticks (edge mode) or 2·duty ticks (centre mode, contiguous across the period boundary).
- Shadow writes:
  - duty_we[i]=1 loads shadow[i] from the duty slice on any clock.
  - Multiple channels may be written in the same cycle.
  - A write on the same clock as a boundary load does not reach active: active takes the old shadow value, and the new value applies from the next period.
- mode changes take effect only at a period boundary or while disabled. A mid-period change never produces a glitch.
- en=0:
  - pcnt, cnt and direction are held at 0/up.
  - active <= shadow and mode_act <= mode on every clock.
  - pwm_out[i] = polarity[i] (inactive level) from the next clock.
  - period_start = 0.
- en rising: the first period starts at cnt=0 with the latest shadow values. No period_start pulse is issued for this first period.
- Reset asserted mid-period overrides all other activity. Outputs are 0 one clock after the reset edge.

Test Plan:
- RES=4, CHANNELS=4, prescale=0, edge mode, en=1. Write ch0=5, ch1=0, ch2=15, ch3=8, then run 2 periods.
  - ch0 is high 5 clocks of every 15. ch1 is constant 0. ch2 is constant 1. ch3 is high 8 of 15.
  - period_start pulses every 15 clocks.
- Centre mode, ch0=5, prescale=0.
  - Period is 30 clocks. ch0 is high for 10 contiguous clocks straddling each boundary.
  - period_start pulses every 30 clocks.
- Active duty 10; write ch0=3 at cnt=4.
  - The current period keeps 10 high clocks. The next period gives 3.
  - A write of 7 on the exact boundary clock leaves the next period at the old value and applies 7 one period later.
- prescale=3, edge mode, ch0=5.
  - Each cnt value lasts 4 clocks, so the period is 60 clocks with 20 high.
  - Changing prescale from 10 to 2 while pcnt=7 produces a tick on the next clock.
- polarity[0]=1, ch0=5.
  - Output is low 5 clocks and high 10 per period.
  - Dropping en at cnt=2 drives pwm_out[0]=1 next clock and holds cnt at 0.
  - Re-enabling restarts the period from cnt=0.
- Switch mode 0→1 mid-period.
  - The edge period completes unchanged, and the centre period starts at the boundary.
  - Asserting reset at cnt=9 gives pwm_out=0 and period_start=0 one clock later, and all duties read back as 0 behaviour (constant inactive).
